// File: rtl/d_mem_arbiter.sv
// ============================================================================
// Module   : d_mem_arbiter
// Purpose  : Two-port arbiter/sequencer for the single-port data memory.
//            Round-robin when D_MEM_ARB_RR_EN is defined, else A-first priority.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module d_mem_arbiter #(
    parameter int MemSize = 10
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        ReqA,
    input  logic        ReqB,
    input  logic        WeA,
    input  logic        WeB,
    input  logic [31:0] AddrA,
    input  logic [31:0] AddrB,
    input  logic [31:0] WDataA,
    input  logic [31:0] WDataB,
    output logic        GntA,
    output logic        GntB,
    output logic        DoneA,
    output logic        DoneB,
    output logic        ErrA,
    output logic        ErrB,
    output logic [31:0] RDataA,
    output logic [31:0] RDataB,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] ReadData
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [32:0] C_ADDR_MAX = (33'd1 << MemSize) - 33'd1;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_we;
    logic        r_err;
    logic        r_win_b;
    logic        w_pick_b;
    logic        w_any_req;
    logic [31:0] w_addr;
    logic        w_addr_bad;
    logic [31:0] w_capture;

    assign w_any_req = ReqA | ReqB;

`ifdef D_MEM_ARB_RR_EN
    logic r_last_b;

    // Contention goes to whichever port was not served last.
    assign w_pick_b = ReqB & (~ReqA | ~r_last_b);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_last_b <= 1'b1;
        end else if (r_state == DONE) begin
            r_last_b <= r_win_b;
        end
    end
`else
    assign w_pick_b = ReqB & ~ReqA;
`endif

    assign w_addr     = w_pick_b ? AddrB : AddrA;
    assign w_addr_bad = {1'b0, w_addr} > C_ADDR_MAX;
    assign w_capture  = (r_we | r_err) ? 32'd0 : ReadData;

    // Address/WriteData are the latched request itself, so they hold outside ACCESS.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= IDLE;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_win_b   <= 1'b0;
            Address   <= 32'd0;
            WriteData <= 32'd0;
            RDataA    <= 32'd0;
            RDataB    <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_any_req) begin
                r_win_b   <= w_pick_b;
                r_we      <= w_pick_b ? WeB : WeA;
                r_err     <= w_addr_bad;
                Address   <= w_addr;
                WriteData <= w_pick_b ? WDataB : WDataA;
            end
            if (r_state == ACCESS) begin
                if (r_win_b) begin
                    RDataB <= w_capture;
                end else begin
                    RDataA <= w_capture;
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        GntA         = 1'b0;
        GntB         = 1'b0;
        DoneA        = 1'b0;
        DoneB        = 1'b0;
        ErrA         = 1'b0;
        ErrB         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                GntA         = ~r_win_b;
                GntB         = r_win_b;
                MemRead      = ~r_we & ~r_err;
                MemWrite     = r_we & ~r_err;
                w_next_state = DONE;
            end
            DONE: begin
                DoneA        = ~r_win_b;
                DoneB        = r_win_b;
                ErrA         = ~r_win_b & r_err;
                ErrB         = r_win_b & r_err;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_d_mem_arbiter.sv
// ============================================================================
// Module   : tb_d_mem_arbiter
// Purpose  : Directed self-checking bench for d_mem_arbiter with a memory model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_d_mem_arbiter;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        ReqA, ReqB, WeA, WeB;
    logic [31:0] AddrA, AddrB, WDataA, WDataB;
    logic        GntA, GntB, DoneA, DoneB, ErrA, ErrB;
    logic [31:0] RDataA, RDataB, Address, WriteData, ReadData;
    logic        MemRead, MemWrite;

    logic [31:0] mem [0:1023];
    int          errors = 0;
    int          checks = 0;

    always #5 Clock = ~Clock;

    assign ReadData = mem[Address[9:0]];
    always @(posedge Clock) begin
        if (MemWrite) mem[Address[9:0]] = WriteData;
    end

    d_mem_arbiter #(.MemSize(10)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .ReqA(ReqA), .ReqB(ReqB), .WeA(WeA), .WeB(WeB),
        .AddrA(AddrA), .AddrB(AddrB), .WDataA(WDataA), .WDataB(WDataB),
        .GntA(GntA), .GntB(GntB), .DoneA(DoneA), .DoneB(DoneB),
        .ErrA(ErrA), .ErrB(ErrB), .RDataA(RDataA), .RDataB(RDataB),
        .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData)
    );

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset;
        Reset_n = 1'b0;
        ReqA = 0; ReqB = 0; WeA = 0; WeB = 0;
        AddrA = 0; AddrB = 0; WDataA = 0; WDataB = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 + i;
        tick; tick;
        checks++;
        if ({GntA, GntB, DoneA, DoneB, ErrA, ErrB, MemRead, MemWrite} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=00000000", {GntA, GntB, DoneA, DoneB, ErrA, ErrB, MemRead, MemWrite});
        end
        checks++;
        if ({Address, WriteData, RDataA, RDataB} !== 128'd0) begin
            errors++;
            $display("FAIL reset_data got=%h exp=0", {Address, WriteData, RDataA, RDataB});
        end
        #3 Reset_n = 1'b1;
        tick;
        checks++;
        if ({GntA, GntB, MemRead, MemWrite} !== 4'h0) begin
            errors++;
            $display("FAIL reset_idle got=%b exp=0000", {GntA, GntB, MemRead, MemWrite});
        end
    endtask

    task automatic test_write_read;
        ReqA = 1; WeA = 1; AddrA = 32'd5; WDataA = 32'hDEAD_BEEF;
        tick;
        checks++;
        if ({GntA, MemWrite, MemRead, Address} !== {3'b110, 32'd5}) begin
            errors++;
            $display("FAIL wr_access got=%b/%0d exp=110/5", {GntA, MemWrite, MemRead}, Address);
        end
        ReqA = 0;
        tick;
        checks++;
        if ({DoneA, ErrA, MemWrite, GntA} !== 4'b1000) begin
            errors++;
            $display("FAIL wr_done got=%b exp=1000", {DoneA, ErrA, MemWrite, GntA});
        end
        tick;
        ReqA = 1; WeA = 0;
        tick;
        checks++;
        if ({GntA, MemRead, MemWrite} !== 3'b110) begin
            errors++;
            $display("FAIL rd_access got=%b exp=110", {GntA, MemRead, MemWrite});
        end
        ReqA = 0;
        tick;
        checks++;
        if ({DoneA, ErrA, RDataA} !== {2'b10, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL rd_done got=%b/%h exp=10/deadbeef", {DoneA, ErrA}, RDataA);
        end
        tick;
    endtask

    task automatic test_contention;
        int     gcount;
        int     gt [4];
        logic   gb [4];
        logic   exp_b [4];
`ifdef D_MEM_ARB_RR_EN
        exp_b = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_b = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        gcount = 0;
        Reset_n = 1'b0;
        #2 Reset_n = 1'b1;
        ReqA = 1; WeA = 0; AddrA = 32'd6;
        ReqB = 1; WeB = 0; AddrB = 32'd7;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            tick;
            if (GntA || GntB) begin
                if (gcount < 4) begin
                    gt[gcount] = cyc;
                    gb[gcount] = GntB;
                end
                gcount++;
            end
            if (cyc == 10) begin
                ReqA = 0; ReqB = 0;
            end
        end
        checks++;
        if (gcount !== 4) begin
            errors++;
            $display("FAIL cont_count got=%0d exp=4", gcount);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (gb[k] !== exp_b[k] || gt[k] !== 1 + 3 * k) begin
                    errors++;
                    $display("FAIL cont_grant%0d got=B%b@%0d exp=B%b@%0d", k, gb[k], gt[k], exp_b[k], 1 + 3 * k);
                end
            end
        end
    endtask

    task automatic test_range_error;
        ReqB = 1; WeB = 0; AddrB = 32'd7;
        tick;
        ReqB = 0;
        tick;
        checks++;
        if ({DoneB, ErrB, RDataB} !== {2'b10, 32'hA500_0007}) begin
            errors++;
            $display("FAIL rng_ok got=%b/%h exp=10/a5000007", {DoneB, ErrB}, RDataB);
        end
        tick;
        ReqB = 1; AddrB = 32'd1024;
        tick;
        checks++;
        if ({GntB, MemRead, MemWrite} !== 3'b100) begin
            errors++;
            $display("FAIL rng_access got=%b exp=100", {GntB, MemRead, MemWrite});
        end
        ReqB = 0;
        tick;
        checks++;
        if ({DoneB, ErrB, MemRead, MemWrite, RDataB} !== {4'b1100, 32'd0}) begin
            errors++;
            $display("FAIL rng_done got=%b/%h exp=1100/0", {DoneB, ErrB, MemRead, MemWrite}, RDataB);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        ReqA = 1; WeA = 0; AddrA = 32'd5;
        tick;
        ReqA = 0;
        ReqB = 1; WeB = 0; AddrB = 32'd6;
        tick;
        checks++;
        if ({DoneA, GntB, RDataA} !== {2'b10, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL b2b_done_a got=%b/%h exp=10/deadbeef", {DoneA, GntB}, RDataA);
        end
        tick;
        checks++;
        if ({GntB, MemRead} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_idle got=%b exp=00", {GntB, MemRead});
        end
        tick;
        checks++;
        if ({GntB, MemRead, Address} !== {2'b11, 32'd6}) begin
            errors++;
            $display("FAIL b2b_gnt_b got=%b/%0d exp=11/6", {GntB, MemRead}, Address);
        end
        ReqB = 0;
        tick;
        checks++;
        if ({DoneB, RDataB, RDataA} !== {1'b1, 32'hA500_0006, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL b2b_done_b got=%b/%h/%h exp=1/a5000006/deadbeef", DoneB, RDataB, RDataA);
        end
        tick;
    endtask

    task automatic test_reset_mid_access;
        ReqA = 1; WeA = 1; AddrA = 32'd9; WDataA = 32'h1234_5678;
        tick;
        checks++;
        if (MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre got=%b exp=1", MemWrite);
        end
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if ({MemWrite, MemRead, GntA} !== 3'b000) begin
            errors++;
            $display("FAIL rst_async got=%b exp=000", {MemWrite, MemRead, GntA});
        end
        ReqA = 0;
        #2 Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if ({DoneA, GntA, MemWrite} !== 3'b000) begin
                errors++;
                $display("FAIL rst_after%0d got=%b exp=000", i, {DoneA, GntA, MemWrite});
            end
        end
        checks++;
        if ({mem[9], Address} !== {32'hA500_0009, 32'd0}) begin
            errors++;
            $display("FAIL rst_mem got=%h/%h exp=a5000009/0", mem[9], Address);
        end
    endtask

    task automatic test_req_in_done;
        ReqA = 1; WeA = 0; AddrA = 32'd5;
        tick;
        ReqA = 0;
        tick;
        ReqB = 1; WeB = 1; AddrB = 32'd3; WDataB = 32'hFFFF_0000;
        #5 ReqB = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++;
            if ({GntA, GntB, MemRead, MemWrite, DoneA, DoneB} !== 6'b0) begin
                errors++;
                $display("FAIL done_pulse%0d got=%b exp=000000", i, {GntA, GntB, MemRead, MemWrite, DoneA, DoneB});
            end
        end
        checks++;
        if (mem[3] !== 32'hA500_0003) begin
            errors++;
            $display("FAIL done_mem got=%h exp=a5000003", mem[3]);
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_contention;
        test_range_error;
        test_back_to_back;
        test_reset_mid_access;
        test_req_in_done;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
